// File: rtl/game_control.sv
// Frame sequencer for the game datapath: init, frame pacing, move/collide/act, then three draw passes.
// Optional GAME_CONTROL_PAUSE_EN adds a pause input that holds the FSM in S_IDLE.
module game_control #(
  parameter int          INIT_CYCLES    = 4,
  parameter int          COLLIDE_CYCLES = 2,
  parameter logic [19:0] DRAW_TIMEOUT   = 20'd131072
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        idle_done,
  input  logic        draw_map_done,
  input  logic        draw_link_done,
  input  logic        draw_enemies_done,
`ifdef GAME_CONTROL_PAUSE_EN
  input  logic        pause,
`endif
  output logic        init,
  output logic        idle,
  output logic        gen_move,
  output logic        check_collide,
  output logic        apply_act_link,
  output logic        move_enemies,
  output logic        draw_map,
  output logic        draw_link,
  output logic        draw_enemies,
  output logic [15:0] frame_count,
  output logic        draw_timeout_err
);

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_APPLY_LINK    = 4'd4,
    S_MOVE_ENEMIES  = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENEMIES  = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [19:0] r_cnt;
  logic [15:0] r_frame_count;
  logic        r_err;
  logic [8:0]  r_strobe;
  logic [8:0]  w_next_strobe;
  logic        w_idle_go;
  logic        w_draw_to;
  logic        w_set_err;
  logic        w_frame_inc;

`ifdef GAME_CONTROL_PAUSE_EN
  assign w_idle_go = idle_done & ~pause;
`else
  assign w_idle_go = idle_done;
`endif

  // One counter serves init, collide and draw states; it restarts on every state change.
  assign w_draw_to = (r_cnt == (DRAW_TIMEOUT - 20'd1));

  always_comb begin
    w_next_state = r_state;
    w_set_err    = 1'b0;
    w_frame_inc  = 1'b0;
    case (r_state)
      S_INIT:          if (r_cnt == 20'(INIT_CYCLES - 1)) w_next_state = S_IDLE;
      S_IDLE:          if (w_idle_go) w_next_state = S_GEN_MOVE;
      S_GEN_MOVE:      w_next_state = S_CHECK_COLLIDE;
      S_CHECK_COLLIDE: if (r_cnt == 20'(COLLIDE_CYCLES - 1)) w_next_state = S_APPLY_LINK;
      S_APPLY_LINK:    w_next_state = S_MOVE_ENEMIES;
      S_MOVE_ENEMIES:  w_next_state = S_DRAW_MAP;
      S_DRAW_MAP: begin
        if (draw_map_done || w_draw_to) begin
          w_next_state = S_DRAW_LINK;
          w_set_err    = ~draw_map_done;
        end
      end
      S_DRAW_LINK: begin
        if (draw_link_done || w_draw_to) begin
          w_next_state = S_DRAW_ENEMIES;
          w_set_err    = ~draw_link_done;
        end
      end
      S_DRAW_ENEMIES: begin
        if (draw_enemies_done || w_draw_to) begin
          w_next_state = S_IDLE;
          w_set_err    = ~draw_enemies_done;
          w_frame_inc  = 1'b1;
        end
      end
      default:         w_next_state = S_INIT;
    endcase
  end

  // Strobes are decoded from the next state so they register in step with r_state.
  always_comb begin
    w_next_strobe = 9'b0;
    case (w_next_state)
      S_INIT:          w_next_strobe[8] = 1'b1;
      S_IDLE:          w_next_strobe[7] = 1'b1;
      S_GEN_MOVE:      w_next_strobe[6] = 1'b1;
      S_CHECK_COLLIDE: w_next_strobe[5] = 1'b1;
      S_APPLY_LINK:    w_next_strobe[4] = 1'b1;
      S_MOVE_ENEMIES:  w_next_strobe[3] = 1'b1;
      S_DRAW_MAP:      w_next_strobe[2] = 1'b1;
      S_DRAW_LINK:     w_next_strobe[1] = 1'b1;
      S_DRAW_ENEMIES:  w_next_strobe[0] = 1'b1;
      default:         w_next_strobe[8] = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= S_INIT;
      r_cnt         <= 20'd0;
      r_frame_count <= 16'd0;
      r_err         <= 1'b0;
      r_strobe      <= 9'b1_0000_0000;
    end else begin
      r_state  <= w_next_state;
      r_cnt    <= (w_next_state != r_state) ? 20'd0 : r_cnt + 20'd1;
      r_strobe <= w_next_strobe;
      if (w_frame_inc) r_frame_count <= r_frame_count + 16'd1;
      if (w_set_err)   r_err         <= 1'b1;
    end
  end

  assign {init, idle, gen_move, check_collide, apply_act_link,
          move_enemies, draw_map, draw_link, draw_enemies} = r_strobe;
  assign frame_count      = r_frame_count;
  assign draw_timeout_err = r_err;

endmodule

// File: tb/tb_game_control.sv
// Bench for game_control: directed frame scenarios plus random traffic against a phase/age model.
module tb_game_control;
  localparam int INIT_CYCLES    = 4;
  localparam int COLLIDE_CYCLES = 2;
  localparam int TMO            = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        idle_done = 1'b0;
  logic        draw_map_done = 1'b0;
  logic        draw_link_done = 1'b0;
  logic        draw_enemies_done = 1'b0;
`ifdef GAME_CONTROL_PAUSE_EN
  logic        pause = 1'b0;
`endif
  logic        init, idle, gen_move, check_collide, apply_act_link;
  logic        move_enemies, draw_map, draw_link, draw_enemies;
  logic [15:0] frame_count;
  logic        draw_timeout_err;
  logic [8:0]  w_strobes;

  game_control #(
    .INIT_CYCLES(INIT_CYCLES),
    .COLLIDE_CYCLES(COLLIDE_CYCLES),
    .DRAW_TIMEOUT(20'(TMO))
  ) dut (
    .clock(clock),
    .reset(reset),
    .idle_done(idle_done),
    .draw_map_done(draw_map_done),
    .draw_link_done(draw_link_done),
    .draw_enemies_done(draw_enemies_done),
`ifdef GAME_CONTROL_PAUSE_EN
    .pause(pause),
`endif
    .init(init),
    .idle(idle),
    .gen_move(gen_move),
    .check_collide(check_collide),
    .apply_act_link(apply_act_link),
    .move_enemies(move_enemies),
    .draw_map(draw_map),
    .draw_link(draw_link),
    .draw_enemies(draw_enemies),
    .frame_count(frame_count),
    .draw_timeout_err(draw_timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  assign w_strobes = {init, idle, gen_move, check_collide, apply_act_link,
                      move_enemies, draw_map, draw_link, draw_enemies};

  // ---------------- reference model ----------------
  // Phases 0..8 in frame order; m_age counts edges spent in the current phase.
  int          m_phase = 0;
  int          m_age = 0;
  logic [15:0] m_frames = 16'd0;
  logic        m_err = 1'b0;
  int          dur[9] = '{INIT_CYCLES, 0, 1, COLLIDE_CYCLES, 1, 1, TMO, TMO, TMO};
  string       phase_name[9] = '{"init", "idle", "gen_move", "check_collide", "apply_act_link",
                                 "move_enemies", "draw_map", "draw_link", "draw_enemies"};

  int checks = 0;
  int errors = 0;
  logic [25:0] exp_q[$];

  task automatic model_edge();
    logic ev;
    logic leave;
    if (!reset) begin
      m_phase  = 0;
      m_age    = 0;
      m_frames = 16'd0;
      m_err    = 1'b0;
      return;
    end
    case (m_phase)
`ifdef GAME_CONTROL_PAUSE_EN
      1:       ev = idle_done && !pause;
`else
      1:       ev = idle_done;
`endif
      6:       ev = draw_map_done;
      7:       ev = draw_link_done;
      8:       ev = draw_enemies_done;
      default: ev = 1'b0;
    endcase
    if (m_phase == 1) leave = ev;
    else if (m_phase >= 6) begin
      leave = ev || (m_age + 1 == TMO);
      if (leave && !ev) m_err = 1'b1;
    end else leave = (m_age + 1 == dur[m_phase]);
    if (leave) begin
      if (m_phase == 8) m_frames = m_frames + 16'd1;
      m_phase = (m_phase == 8) ? 1 : m_phase + 1;
      m_age   = 0;
    end else m_age++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [25:0] obs;
    logic [25:0] exp;
    model_edge();
    exp_q.push_back({m_err, m_frames, 9'b1_0000_0000 >> m_phase});
    @(posedge clock);
    #1;
    obs = {draw_timeout_err, frame_count, w_strobes};
    exp = exp_q.pop_front();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL cycle[%s] observed=%h expected=%h", phase_name[m_phase], obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive_done(input int sel, input logic v);
    case (sel)
      1: draw_map_done     = v;
      2: draw_link_done    = v;
      3: draw_enemies_done = v;
      4: idle_done         = v;
      default: ;
    endcase
  endtask

  // Steps while phase ph's strobe is high; pulses done flag sel in cycle done_at of the phase.
  task automatic run_phase(input int ph, input int sel, input int done_at, output int n);
    n = 0;
    while (w_strobes[8-ph] === 1'b1 && n < 64) begin
      n++;
      drive_done(sel, n == done_at);
      step();
      drive_done(sel, 1'b0);
    end
  endtask

  task automatic pulse_idle_done();
    idle_done = 1'b1;
    step();
    idle_done = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int n;
    int frame_cycles;

    // Reset held, then released: init lasts INIT_CYCLES cycles.
    repeat (3) step();
    reset = 1'b1;
    run_phase(0, 0, 0, n);
    check_val("init_cycles", n, INIT_CYCLES);
    repeat (5) step();
    check_val("idle_hold", idle, 1);

    // One frame with done flags returned 10 cycles into each draw state.
    pulse_idle_done();
    run_phase(2, 0, 0, n); check_val("gen_move_len", n, 1);
    run_phase(3, 0, 0, n); check_val("collide_len", n, COLLIDE_CYCLES);
    run_phase(4, 0, 0, n); check_val("apply_len", n, 1);
    run_phase(5, 0, 0, n); check_val("move_len", n, 1);
    run_phase(6, 1, 10, n); check_val("draw_map_len", n, 10);
    run_phase(7, 2, 10, n); check_val("draw_link_len", n, 10);
    run_phase(8, 3, 10, n); check_val("draw_enemies_len", n, 10);
    check_val("idle_after_frame", idle, 1);
    check_val("frame_count_1", frame_count, 1);

    // Done flags held high: shortest possible frame.
    repeat (2) step();
    draw_map_done = 1'b1; draw_link_done = 1'b1; draw_enemies_done = 1'b1;
    pulse_idle_done();
    frame_cycles = 0;
    while (idle !== 1'b1 && frame_cycles < 64) begin
      frame_cycles++;
      step();
    end
    check_val("fast_frame_cycles", frame_cycles, 8);
    draw_map_done = 1'b0; draw_link_done = 1'b0; draw_enemies_done = 1'b0;
    check_val("frame_count_2", frame_count, 2);

    // draw_link never completes: timeout forces the advance and sets the sticky flag.
    pulse_idle_done();
    for (int p = 2; p <= 5; p++) run_phase(p, 0, 0, n);
    run_phase(6, 1, 3, n);
    run_phase(7, 0, 0, n); check_val("draw_link_timeout_len", n, TMO);
    check_val("timeout_to_enemies", draw_enemies, 1);
    check_val("timeout_err_set", draw_timeout_err, 1);
    run_phase(8, 3, 2, n);
    repeat (4) step();
    check_val("timeout_err_sticky", draw_timeout_err, 1);

    // Reset in the 5th cycle of draw_map aborts the frame.
    pulse_idle_done();
    for (int p = 2; p <= 5; p++) run_phase(p, 0, 0, n);
    repeat (4) step();
    check_val("in_draw_map", draw_map, 1);
    reset = 1'b0;
    step();
    check_val("reset_init", init, 1);
    check_val("reset_frame_count", frame_count, 0);
    check_val("reset_err", draw_timeout_err, 0);
    reset = 1'b1;
    run_phase(0, 0, 0, n);
    check_val("init_cycles_again", n, INIT_CYCLES);

`ifdef GAME_CONTROL_PAUSE_EN
    // Paused: idle_done pulses are ignored until pause drops.
    pause = 1'b1;
    repeat (3) begin
      pulse_idle_done();
      step();
      check_val("pause_hold_idle", idle, 1);
    end
    pause = 1'b0;
    pulse_idle_done();
    check_val("unpause_gen_move", gen_move, 1);
    for (int p = 2; p <= 5; p++) run_phase(p, 0, 0, n);
    run_phase(6, 1, 1, n);
    run_phase(7, 2, 1, n);
    run_phase(8, 3, 1, n);
`endif

    // Random traffic, including spurious done flags and occasional resets.
    for (int c = 0; c < 800; c++) begin
      reset             = ($urandom_range(0, 149) != 0);
      idle_done         = ($urandom_range(0, 3) == 0);
      draw_map_done     = ($urandom_range(0, 4) == 0);
      draw_link_done    = ($urandom_range(0, 4) == 0);
      draw_enemies_done = ($urandom_range(0, 4) == 0);
`ifdef GAME_CONTROL_PAUSE_EN
      pause             = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    reset = 1'b1;
    idle_done = 1'b0; draw_map_done = 1'b0; draw_link_done = 1'b0; draw_enemies_done = 1'b0;
    repeat (3) step();

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
